// File: rtl/ins_wb_arbiter.sv
// Write-back arbiter: N_REQ execute units, each with a one-entry hold buffer,
// share the single register-file write port through a round-robin grant.
module ins_wb_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 5,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_w_op,
    input  logic [N_REQ*IDX_W-1:0] req_w_reg_idx,
    input  logic [N_REQ*XLEN-1:0]  req_w_reg_val,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   wb_stall,
    output logic                   reg_w_op,
    output logic [IDX_W-1:0]       reg_w_reg_idx,
    output logic [XLEN-1:0]        reg_w_reg_val,
    output logic                   busy
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ-1:0] full;
    logic [IDX_W-1:0] buf_idx [N_REQ];
    logic [XLEN-1:0]  buf_val [N_REQ];
    logic [PTR_W-1:0] ptr;

    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic [N_REQ-1:0] xfer;
    int               cand;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        grant_any = 1'b0;
        cand      = 0;
        if (!wb_stall) begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = int'(ptr) + k;
                if (cand >= N_REQ) cand = cand - N_REQ;
                if (!grant_any && full[PTR_W'(cand)]) begin
                    grant_any = 1'b1;
                    grant_idx = PTR_W'(cand);
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    // A granted buffer drains on the same edge it refills, so a lone requester
    // still sustains one write per cycle.
    assign req_ready = rst_n ? (~full | grant) : '0;
    assign xfer      = req_w_op & req_ready;
    assign busy      = (|full) | reg_w_op;

    // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full          <= '0;
            ptr           <= PTR_W'(N_REQ - 1);
            reg_w_op      <= 1'b0;
            reg_w_reg_idx <= '0;
            reg_w_reg_val <= '0;
            // NOTE: the hold buffers are tiny, so they are reset for a fully defined state.
            for (int i = 0; i < N_REQ; i++) begin
                buf_idx[i] <= '0;
                buf_val[i] <= '0;
            end
        end else begin
            reg_w_op <= grant_any;
            if (grant_any) begin
                reg_w_reg_idx <= buf_idx[grant_idx];
                reg_w_reg_val <= buf_val[grant_idx];
                ptr           <= grant_idx;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (xfer[i]) begin
                    // Writes to x0 are accepted but leave the buffer empty.
                    full[i]    <= (req_w_reg_idx[i*IDX_W +: IDX_W] != '0);
                    buf_idx[i] <= req_w_reg_idx[i*IDX_W +: IDX_W];
                    buf_val[i] <= req_w_reg_val[i*XLEN +: XLEN];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ins_wb_arbiter.sv
// Self-checking bench for ins_wb_arbiter: directed scenarios plus random traffic,
// all compared every cycle against a per-requester reference model.
module tb_ins_wb_arbiter;

    localparam int N  = 4;
    localparam int IW = 5;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_w_op;
    logic [N*IW-1:0] req_w_reg_idx;
    logic [N*XL-1:0] req_w_reg_val;
    logic [N-1:0]    req_ready;
    logic            wb_stall;
    logic            reg_w_op;
    logic [IW-1:0]   reg_w_reg_idx;
    logic [XL-1:0]   reg_w_reg_val;
    logic            busy;

    ins_wb_arbiter #(.N_REQ(N), .IDX_W(IW), .XLEN(XL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_w_op      (req_w_op),
        .req_w_reg_idx (req_w_reg_idx),
        .req_w_reg_val (req_w_reg_val),
        .req_ready     (req_ready),
        .wb_stall      (wb_stall),
        .reg_w_op      (reg_w_op),
        .reg_w_reg_idx (reg_w_reg_idx),
        .reg_w_reg_val (reg_w_reg_val),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending write per requester, last requester served,
    // and the write-back register contents.
    bit            m_full [N];
    logic [IW-1:0] m_idx  [N];
    logic [XL-1:0] m_val  [N];
    bit            m_xfer [N];
    int            m_ptr;
    bit            m_wop;
    logic [IW-1:0] m_widx;
    logic [XL-1:0] m_wval;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0;
            m_idx[i]  = '0;
            m_val[i]  = '0;
            m_xfer[i] = 0;
        end
        m_ptr  = N - 1;
        m_wop  = 0;
        m_widx = '0;
        m_wval = '0;
    endtask

    // Served next: the pending requester closest after the last one served.
    function automatic int m_pick();
        int best  = -1;
        int bestd = N;
        if (wb_stall) return -1;
        for (int c = 0; c < N; c++) begin
            int d = (c - m_ptr - 1 + 2 * N) % N;
            if (m_full[c] && d < bestd) begin
                best  = c;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g = m_pick();
        for (int i = 0; i < N; i++) r[i] = !m_full[i] || (g == i);
        return r;
    endfunction

    function automatic logic m_busy();
        logic b = m_wop;
        for (int i = 0; i < N; i++) b = b | m_full[i];
        return b;
    endfunction

    task automatic model_edge();
        int           g = m_pick();
        logic [N-1:0] r = m_ready();
        if (g >= 0) begin
            m_wop     = 1;
            m_widx    = m_idx[g];
            m_wval    = m_val[g];
            m_ptr     = g;
            m_full[g] = 0;
        end else begin
            m_wop = 0;
        end
        for (int i = 0; i < N; i++) begin
            m_xfer[i] = req_w_op[i] && r[i];
            if (m_xfer[i]) begin
                if (req_w_reg_idx[i*IW +: IW] != '0) begin
                    m_full[i] = 1;
                    m_idx[i]  = req_w_reg_idx[i*IW +: IW];
                    m_val[i]  = req_w_reg_val[i*XL +: XL];
                end else begin
                    m_full[i] = 0;
                end
            end
        end
    endtask

    task automatic settle();
        #1;
        check("ready", req_ready, m_ready());
        check("busy", busy, m_busy());
        check("w_op", reg_w_op, m_wop);
        check("w_idx", reg_w_reg_idx, m_widx);
        check("w_val", reg_w_reg_val, m_wval);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic set_req(input int i, input logic op, input logic [IW-1:0] idx, input logic [XL-1:0] val);
        req_w_op[i]              = op;
        req_w_reg_idx[i*IW +: IW] = idx;
        req_w_reg_val[i*XL +: XL] = val;
    endtask

    task automatic clear_req();
        req_w_op      = '0;
        req_w_reg_idx = '0;
        req_w_reg_val = '0;
    endtask

    task automatic reset_checks();
        #1;
        model_reset();
        check("rst_w_op", reg_w_op, 1'b0);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_busy", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int           s0;
        int           s2;
        int           e0;
        int           e2;
        logic [IW-1:0] last_idx;
        bit           have_last;

        rst_n    = 1'b0;
        wb_stall = 1'b0;
        clear_req();
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_idx", reg_w_reg_idx, 5'd0);
        check("rst_val", reg_w_reg_val, 32'd0);

        // Single write, two-cycle latency.
        set_req(0, 1'b1, 5'd5, 32'h1234_5678);
        tick();
        clear_req();
        tick();
        settle();
        check("t1_op_c3", reg_w_op, 1'b1);
        check("t1_idx_c3", reg_w_reg_idx, 5'd5);
        check("t1_val_c3", reg_w_reg_val, 32'h1234_5678);
        advance();
        settle();
        check("t1_op_c4", reg_w_op, 1'b0);
        check("t1_busy_c4", busy, 1'b0);
        advance();

        // Four simultaneous requests drain in requester order.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, IW'(i + 1), XL'(32'hB000_0000 + i));
        tick();
        clear_req();
        for (int c = 2; c <= 6; c++) begin
            settle();
            check("t2_ready3", req_ready[3], (c == 5 || c == 6) ? 1'b1 : 1'b0);
            if (c >= 3) begin
                check("t2_op", reg_w_op, 1'b1);
                check("t2_idx", reg_w_reg_idx, 5'(c - 2));
            end
            advance();
        end
        repeat (2) tick();

        // Round-robin between two always-busy requesters.
        do_reset();
        s0 = 0; s2 = 0; e0 = 0; e2 = 0;
        have_last = 0;
        last_idx  = '0;
        for (int c = 0; c < 14; c++) begin
            set_req(0, 1'b1, 5'd10, XL'(32'hA000_0000 + s0));
            set_req(2, 1'b1, 5'd12, XL'(32'hC000_0000 + s2));
            settle();
            if (reg_w_op) begin
                if (have_last) check("t3_alternate", reg_w_reg_idx, (last_idx == 5'd10) ? 5'd12 : 5'd10);
                if (reg_w_reg_idx == 5'd10) begin
                    check("t3_order0", reg_w_reg_val, XL'(32'hA000_0000 + e0));
                    e0++;
                end else begin
                    check("t3_order2", reg_w_reg_val, XL'(32'hC000_0000 + e2));
                    e2++;
                end
                last_idx  = reg_w_reg_idx;
                have_last = 1;
            end
            advance();
            if (m_xfer[0]) s0++;
            if (m_xfer[2]) s2++;
        end
        clear_req();
        repeat (4) tick();
        check("t3_count0", e0 >= 5, 1'b1);
        check("t3_count2", e2 >= 5, 1'b1);

        // Writes to x0 are swallowed.
        for (int c = 0; c < 3; c++) begin
            set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
            settle();
            check("t4_ready1", req_ready[1], 1'b1);
            check("t4_op", reg_w_op, 1'b0);
            check("t4_busy", busy, 1'b0);
            advance();
        end
        clear_req();
        repeat (2) begin
            settle();
            check("t4_op_after", reg_w_op, 1'b0);
            advance();
        end

        // Stall holds full buffers, then they drain in order.
        do_reset();
        set_req(0, 1'b1, 5'd7, 32'h0000_0A0A);
        set_req(1, 1'b1, 5'd8, 32'h0000_0B0B);
        wb_stall = 1'b1;
        tick();
        clear_req();
        for (int c = 0; c < 5; c++) begin
            settle();
            check("t5_op_stall", reg_w_op, 1'b0);
            check("t5_ready_stall", req_ready[1:0], 2'b00);
            check("t5_busy_stall", busy, 1'b1);
            advance();
        end
        wb_stall = 1'b0;
        tick();
        settle();
        check("t5_first_idx", reg_w_reg_idx, 5'd7);
        check("t5_first_val", reg_w_reg_val, 32'h0000_0A0A);
        advance();
        settle();
        check("t5_second_idx", reg_w_reg_idx, 5'd8);
        check("t5_second_val", reg_w_reg_val, 32'h0000_0B0B);
        advance();
        repeat (2) tick();

        // Reset in the middle of a write-back burst.
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, IW'(i + 20), XL'(32'hD000_0000 + i));
        wb_stall = 1'b1;
        tick();
        clear_req();
        tick();
        wb_stall = 1'b0;
        set_req(0, 1'b1, 5'd30, 32'hDEAD_0030);
        tick();
        clear_req();
        settle();
        check("t6_op_before", reg_w_op, 1'b1);
        #1;
        rst_n = 1'b0;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            settle();
            check("t6_no_stale", reg_w_op, 1'b0);
            advance();
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b1, IW'(i + 1), XL'(32'hE000_0000 + i));
        tick();
        clear_req();
        tick();
        settle();
        check("t6_prio_idx", reg_w_reg_idx, 5'd1);
        advance();
        repeat (4) tick();

        // Random traffic against the model, with one reset in the middle.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), IW'($urandom_range(0, 31)), XL'($urandom));
            wb_stall = ($urandom_range(0, 3) == 0);
            if (c == 200) begin
                #2;
                rst_n = 1'b0;
                reset_checks();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        clear_req();
        wb_stall = 1'b0;
        repeat (6) tick();
        settle();
        check("final_idle_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
